// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions, opcode/func encodings.
// Also provides the writeback-hit helper used by the optional REGFILE_BYPASS_EN forwarding path.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int F1_MSB = 11;
    localparam int F1_LSB = 8;
    localparam int F2_MSB = 7;
    localparam int F2_LSB = 4;
    localparam int F3_MSB = 3;
    localparam int F3_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADDREG = 4'd0,
        OP_SUBREG = 4'd1,
        OP_ANDREG = 4'd2,
        OP_ORREG  = 4'd3,
        OP_XORREG = 4'd4,
        OP_SHIFT  = 4'd5,
        OP_ADDIMM = 4'd6,
        OP_LDWD   = 4'd7,
        OP_STRWD  = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        FUNC_SHL = 2'd0,
        FUNC_SHR = 2'd1,
        FUNC_SAR = 2'd2
    } func_e;

    // True when a writeback this cycle lands on a real (non-R0) register at addr.
    function automatic logic wb_hit(input logic [ADDR_W-1:0] addr,
                                    input logic              we,
                                    input logic [ADDR_W-1:0] waddr);
        return we && (waddr == addr) && (addr != '0);
    endfunction

endpackage

// File: rtl/regfile_3r1w.sv
// 16x16 register file, three combinational read ports and one write port; R0 is hard zero.
// With REGFILE_BYPASS_EN defined, each read port forwards a same-cycle writeback.
module regfile_3r1w
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic [ADDR_W-1:0] raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_reg [NREGS];
    logic [ADDR_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdata [3];

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign raddr[2] = raddr_c;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];
    assign rdata_c  = rdata[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_reg[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
            assign rdata[gi] = (raddr[gi] == '0)              ? '0    :
                               wb_hit(raddr[gi], we, waddr)  ? wdata :
                                                               mem_reg[raddr[gi]];
`else
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : mem_reg[raddr[gi]];
`endif
        end
    endgenerate

endmodule

// File: rtl/id_regread_stage.sv
// Decode/register-read stage: operand address steering, 3R1W register file and the ID/EX register.
// Optional REGFILE_BYPASS_EN adds writeback forwarding into reads and into held (stalled) operands.
module id_regread_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ReadRegSrc1,
    input  logic              ReadRegSrc2,
    input  logic              ReadRegSrc3,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [1:0]        ex_func,
    output logic [3:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_c
);

    logic [ADDR_W-1:0] f1, f2, f3;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
    logic [DATA_W-1:0] rd_a, rd_b, rd_c;

    logic              ex_valid_reg;
    logic [3:0]        ex_opcode_reg;
    logic [1:0]        ex_func_reg;
    logic [3:0]        ex_rd_reg;
    logic [DATA_W-1:0] ex_a_reg, ex_b_reg, ex_c_reg;
`ifdef REGFILE_BYPASS_EN
    logic [ADDR_W-1:0] ex_addr_a_reg, ex_addr_b_reg, ex_addr_c_reg;
`endif

    assign f1 = instr_in[F1_MSB:F1_LSB];
    assign f2 = instr_in[F2_MSB:F2_LSB];
    assign f3 = instr_in[F3_MSB:F3_LSB];

    // Only a clean 1 takes the alternate field; x/z fall back to the default field.
    assign addr_a = (ReadRegSrc1 === 1'b1) ? f2 : f1;
    assign addr_b = (ReadRegSrc2 === 1'b1) ? f1 : f2;
    assign addr_c = (ReadRegSrc3 === 1'b1) ? f1 : f3;

    assign instr_ready = !stall_in;

    regfile_3r1w u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (addr_a),
        .raddr_b (addr_b),
        .raddr_c (addr_c),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .rdata_c (rd_c),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_opcode_reg <= '0;
            ex_func_reg   <= '0;
            ex_rd_reg     <= '0;
            ex_a_reg      <= '0;
            ex_b_reg      <= '0;
            ex_c_reg      <= '0;
`ifdef REGFILE_BYPASS_EN
            ex_addr_a_reg <= '0;
            ex_addr_b_reg <= '0;
            ex_addr_c_reg <= '0;
`endif
        end else if (flush_in) begin
            ex_valid_reg <= 1'b0;
        end else if (stall_in) begin
`ifdef REGFILE_BYPASS_EN
            // Held operands must not go stale while EX waits on a producer.
            if (ex_valid_reg) begin
                if (wb_hit(ex_addr_a_reg, wb_we, wb_addr)) ex_a_reg <= wb_data;
                if (wb_hit(ex_addr_b_reg, wb_we, wb_addr)) ex_b_reg <= wb_data;
                if (wb_hit(ex_addr_c_reg, wb_we, wb_addr)) ex_c_reg <= wb_data;
            end
`endif
        end else if (instr_valid) begin
            ex_valid_reg  <= 1'b1;
            ex_opcode_reg <= instr_in[OP_MSB:OP_LSB];
            ex_func_reg   <= instr_in[F3_LSB+1:F3_LSB];
            ex_rd_reg     <= f3;
            ex_a_reg      <= rd_a;
            ex_b_reg      <= rd_b;
            ex_c_reg      <= rd_c;
`ifdef REGFILE_BYPASS_EN
            ex_addr_a_reg <= addr_a;
            ex_addr_b_reg <= addr_b;
            ex_addr_c_reg <= addr_c;
`endif
        end else begin
            ex_valid_reg <= 1'b0;
        end
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_opcode = ex_opcode_reg;
    assign ex_func   = ex_func_reg;
    assign ex_rd     = ex_rd_reg;
    assign ex_a      = ex_a_reg;
    assign ex_b      = ex_b_reg;
    assign ex_c      = ex_c_reg;

endmodule

// File: tb/tb_id_regread_stage.sv
// Directed plus randomized bench for id_regread_stage, checked against an array-based register model.
module tb_id_regread_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        ReadRegSrc1, ReadRegSrc2, ReadRegSrc3;
    logic        stall_in, flush_in;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [1:0]  ex_func;
    logic [3:0]  ex_rd;
    logic [15:0] ex_a, ex_b, ex_c;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // reference model state
    logic [15:0] m_rf [16];
    logic        m_v;
    logic [3:0]  m_op, m_rd;
    logic [1:0]  m_fn;
    logic [15:0] m_a, m_b, m_c;
    logic [3:0]  m_aa, m_ab, m_ac;

    id_regread_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ReadRegSrc1 (ReadRegSrc1),
        .ReadRegSrc2 (ReadRegSrc2),
        .ReadRegSrc3 (ReadRegSrc3),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_func     (ex_func),
        .ex_rd       (ex_rd),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_c        (ex_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (BYP && wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        m_v = 1'b0; m_op = '0; m_rd = '0; m_fn = '0;
        m_a = '0; m_b = '0; m_c = '0;
        m_aa = '0; m_ab = '0; m_ac = '0;
    endtask

    // Apply the stage rules for the edge about to happen, using the current inputs.
    task automatic model_edge();
        logic [3:0] f1, f2, f3, aa, ab, ac;
        f1 = instr_in[11:8];
        f2 = instr_in[7:4];
        f3 = instr_in[3:0];
        aa = (ReadRegSrc1 === 1'b1) ? f2 : f1;
        ab = (ReadRegSrc2 === 1'b1) ? f1 : f2;
        ac = (ReadRegSrc3 === 1'b1) ? f1 : f3;
        if (flush_in) begin
            m_v = 1'b0;
        end else if (stall_in) begin
            if (BYP && m_v && wb_we && wb_addr != 4'd0) begin
                if (m_aa == wb_addr) m_a = wb_data;
                if (m_ab == wb_addr) m_b = wb_data;
                if (m_ac == wb_addr) m_c = wb_data;
            end
        end else if (instr_valid) begin
            m_v  = 1'b1;
            m_op = instr_in[15:12];
            m_fn = f3[1:0];
            m_rd = f3;
            m_a  = mread(aa);
            m_b  = mread(ab);
            m_c  = mread(ac);
            m_aa = aa; m_ab = ab; m_ac = ac;
        end else begin
            m_v = 1'b0;
        end
        if (wb_we && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("instr_ready", {15'b0, instr_ready}, {15'b0, !stall_in});
        chk("ex_valid", {15'b0, ex_valid}, {15'b0, m_v});
        if (m_v) begin
            chk("ex_opcode", {12'b0, ex_opcode}, {12'b0, m_op});
            chk("ex_func", {14'b0, ex_func}, {14'b0, m_fn});
            chk("ex_rd", {12'b0, ex_rd}, {12'b0, m_rd});
            chk("ex_a", ex_a, m_a);
            chk("ex_b", ex_b, m_b);
            chk("ex_c", ex_c, m_c);
        end
        $display("cycle t=%0t instr=%h v=%b stall=%b flush=%b wb=%b:%h=%h -> ex_valid=%b a=%h b=%h c=%h",
                 $time, instr_in, instr_valid, stall_in, flush_in, wb_we, wb_addr, wb_data,
                 ex_valid, ex_a, ex_b, ex_c);
    endtask

    task automatic idle();
        instr_valid = 1'b0; stall_in = 1'b0; flush_in = 1'b0; wb_we = 1'b0;
        ReadRegSrc1 = 1'b0; ReadRegSrc2 = 1'b0; ReadRegSrc3 = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        idle();
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        cycle();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [2:0] src);
        instr_in = ins; instr_valid = 1'b1;
        ReadRegSrc1 = src[0]; ReadRegSrc2 = src[1]; ReadRegSrc3 = src[2];
        cycle();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_in = '0; wb_addr = '0; wb_data = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", {15'b0, ex_valid}, 16'h0000);
        chk("reset_ex_a", ex_a, 16'h0000);
        rst = 1'b0;

        // asynchronous reset mid-operation
        wr(4'd5, 16'h1234);
        issue(16'h7500, 3'b000);
        chk("t1_pre_a", ex_a, 16'h1234);
        #3 rst = 1'b1;
        #1;
        chk("t1_async_valid", {15'b0, ex_valid}, 16'h0000);
        chk("t1_async_a", ex_a, 16'h0000);
        model_reset();
        #1 rst = 1'b0;
        issue(16'h7500, 3'b000);
        chk("t1_r5_cleared", ex_a, 16'h0000);

        // address mux steering
        wr(4'd1, 16'h0011);
        wr(4'd2, 16'h0022);
        wr(4'd3, 16'h0033);
        issue(16'h1123, 3'b000);
        chk("t2_a_000", ex_a, 16'h0011);
        chk("t2_b_000", ex_b, 16'h0022);
        chk("t2_c_000", ex_c, 16'h0033);
        issue(16'h1123, 3'b111);
        chk("t2_a_111", ex_a, 16'h0022);
        chk("t2_b_111", ex_b, 16'h0011);
        chk("t2_c_111", ex_c, 16'h0011);

        // R0 write ignored
        wr(4'd0, 16'hFFFF);
        issue(16'h2000, 3'b000);
        chk("t3_r0", ex_a, 16'h0000);

        // stall holds, flush beats stall
        issue(16'h3123, 3'b000);
        stall_in = 1'b1; instr_valid = 1'b1; instr_in = 16'h4456;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_stall_valid", {15'b0, ex_valid}, 16'h0001);
            chk("t4_stall_a", ex_a, 16'h0011);
        end
        flush_in = 1'b1;
        cycle();
        chk("t4_flush_valid", {15'b0, ex_valid}, 16'h0000);
        idle();

        // same-cycle writeback
        wr(4'd4, 16'h00AA);
        wb_we = 1'b1; wb_addr = 4'd4; wb_data = 16'h00BB;
        issue(16'h0400, 3'b000);
        chk("t5_same_cycle", ex_a, BYP ? 16'h00BB : 16'h00AA);
        wb_we = 1'b0;

        // undefined select takes the default field
        wr(4'd6, 16'h0066);
        instr_in = 16'h0600; instr_valid = 1'b1;
        ReadRegSrc1 = 1'bx; ReadRegSrc2 = 1'b0; ReadRegSrc3 = 1'b0;
        cycle();
        chk("t6_xsel", ex_a, 16'h0066);
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            instr_in    = 16'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            stall_in    = ($urandom_range(0, 3) == 0);
            flush_in    = ($urandom_range(0, 9) == 0);
            ReadRegSrc1 = 1'($urandom);
            ReadRegSrc2 = 1'($urandom);
            ReadRegSrc3 = 1'($urandom);
            wb_we       = 1'($urandom);
            wb_addr     = 4'($urandom);
            wb_data     = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
